// File: rtl/output_display_pkg.sv
// rtl/output_display_pkg.sv - shared constants, state type and helpers for the decimal output port
package output_display_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, ENCODE} state_t;

   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   // Active-low {g,f,e,d,c,b,a} patterns, digit 9 in the top slice down to digit 0 at the bottom
   localparam logic [69:0] SEG_TABLE = {
      7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
      7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
   };

   // Segment pattern for one BCD nibble; non-decimal codes show blank
   function automatic logic [6:0] seg_code(input logic [3:0] nib);
      if (nib <= 4'd9)
         return SEG_TABLE[7*int'(nib) +: 7];
      else
         return SEG_BLANK;
   endfunction

   // Decimal digits needed for the largest w-bit unsigned value: floor(w*log10(2)) + 1
   function automatic int bcd_digits(input int w);
      return (w * 30103) / 100000 + 1;
   endfunction

endpackage

// File: rtl/bcd_serial.sv
// rtl/bcd_serial.sv - serial double-dabble binary to BCD converter, one bit per cycle
module bcd_serial
   import output_display_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              start,
   input  logic [DATA_W-1:0]                 bin,
   output logic                              busy,
   output logic [4*bcd_digits(DATA_W)-1:0]   bcd
);

   localparam int ND = bcd_digits(DATA_W);
   localparam int CW = $clog2(DATA_W + 1);

   // BCD accumulator sits above the binary shift register so one shift moves a bit across
   logic [4*ND+DATA_W-1:0] acc;
   logic [4*ND-1:0]        adj;
   logic [CW-1:0]          cnt;

   assign bcd  = acc[4*ND+DATA_W-1 -: 4*ND];
   assign busy = (cnt != '0);

   // Add 3 to every BCD nibble that is 5 or more before the next shift
   always_comb begin
      adj = '0;
      for (int i = 0; i < ND; i++) begin
         if (bcd[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         else
            adj[4*i +: 4] = bcd[4*i +: 4];
      end
   end

   // Load on start, then DATA_W adjust-and-shift steps
   always_ff @(posedge clk) begin
      if (reset) begin
         acc <= '0;
         cnt <= '0;
      end else if (start) begin
         acc <= {{(4*ND){1'b0}}, bin};
         cnt <= CW'(DATA_W);
      end else if (cnt != '0) begin
         acc <= {adj, acc[DATA_W-1:0]} << 1;
         cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/output_display_ctrl.sv
// rtl/output_display_ctrl.sv - memory-mapped decimal output port driving active-low 7-segment digits
module output_display_ctrl
   import output_display_pkg::*;
#(
   parameter int          DATA_W        = 32,
   parameter int          DIGITS        = 8,
   parameter logic [6:0]  OUT_ADDR      = 7'h7F,
   parameter int          SIGNED        = 0,
   parameter int          BLANK_LEADING = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  write,
   input  logic [6:0]            address,
   input  logic [DATA_W-1:0]     in,
   output logic [DATA_W-1:0]     out,
   output logic                  busy,
   output logic                  done,
   output logic [7*DIGITS-1:0]   seg
);

   localparam int ND = bcd_digits(DATA_W);
   localparam int NP = (ND > DIGITS) ? ND : DIGITS;

   state_t              state;
   logic                pend_valid;
   logic [DATA_W-1:0]   pend_data;
   logic                neg;

   logic                accept;
   logic [DATA_W-1:0]   src;
   logic                src_neg;
   logic                conv_start;
   logic [DATA_W-1:0]   conv_bin;
   logic                conv_busy;
   logic [4*ND-1:0]     conv_bcd;

   logic [4*NP-1:0]     bcd_pad;
   logic [7*DIGITS-1:0] seg_next;
   logic [6:0]          pat;
   logic                ovf;
   int                  msd;
   int                  sign_pos;

   // Pick the word to convert (older pending word first) and its magnitude
   always_comb begin
      accept     = write && (address == OUT_ADDR);
      src        = (state == ENCODE && pend_valid) ? pend_data : in;
      src_neg    = (SIGNED != 0) && src[DATA_W-1];
      conv_bin   = src_neg ? -src : src;
      conv_start = (state == IDLE && accept) ||
                   (state == ENCODE && (pend_valid || accept));
   end

   bcd_serial #(.DATA_W(DATA_W)) u_bcd (
      .clk   (clk),
      .reset (reset),
      .start (conv_start),
      .bin   (conv_bin),
      .busy  (conv_busy),
      .bcd   (conv_bcd)
   );

   // Turn the finished BCD value into digit patterns with sign, overflow and blanking
   always_comb begin
      bcd_pad = '0;
      bcd_pad[4*ND-1:0] = conv_bcd;
      msd = 0;
      for (int i = 0; i < ND; i++) begin
         if (conv_bcd[4*i +: 4] != 4'd0)
            msd = i;
      end
      ovf      = neg ? (msd + 1 > DIGITS - 1) : (msd + 1 > DIGITS);
      sign_pos = (BLANK_LEADING != 0) ? msd + 1 : DIGITS - 1;
      pat      = SEG_BLANK;
      seg_next = '0;
      for (int i = 0; i < DIGITS; i++) begin
         pat = seg_code(bcd_pad[4*i +: 4]);
         if (BLANK_LEADING != 0 && i > msd && i != 0)
            pat = SEG_BLANK;
         if (neg && i == sign_pos)
            pat = SEG_DASH;
         if (ovf)
            pat = SEG_DASH;
         seg_next[7*i +: 7] = pat;
      end
   end

   // Control FSM, pending buffer and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         pend_valid <= 1'b0;
         pend_data  <= '0;
         neg        <= 1'b0;
         out        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         for (int i = 0; i < DIGITS; i++)
            seg[7*i +: 7] <= (i == 0 || BLANK_LEADING == 0) ? seg_code(4'd0) : SEG_BLANK;
      end else begin
         done <= 1'b0;
         if (accept)
            out <= in;
         case (state)
            IDLE: begin
               busy <= accept;
               if (accept) begin
                  neg   <= src_neg;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               busy <= 1'b1;
               if (accept) begin
                  pend_valid <= 1'b1;
                  pend_data  <= in;
               end
               if (!conv_busy)
                  state <= ENCODE;
            end
            ENCODE: begin
               busy <= 1'b1;
               seg  <= seg_next;
               done <= 1'b1;
               if (pend_valid) begin
                  neg        <= src_neg;
                  state      <= SHIFT;
                  pend_valid <= accept;
                  if (accept)
                     pend_data <= in;
               end else if (accept) begin
                  neg   <= src_neg;
                  state <= SHIFT;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
